// File: rtl/sum_requant_pack.sv
// Accumulates signed partial sums into pixels, requantizes them to 1/2/4/8 bits
// and packs the pixels LSB-first into DWD-bit words on a valid/ready stream.
module sum_requant_pack #(
    parameter int DWD     = 16,
    parameter int ASUMDWD = 18,
    parameter int ACCWD   = 24
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cfg_vld,
    input  logic [2:0]         i_mode,     // 0 XNOR, 1 M1, 2 M2, 3 M4, 4 M8
    input  logic               i_oNumT,    // 0 SIGNED, 1 UNSIGNED
    input  logic [4:0]         i_shift,
    input  logic [7:0]         i_accnum,
    input  logic               i_sum_vld,
    input  logic [ASUMDWD-1:0] i_sum,
    input  logic               i_last,
    output logic               o_sum_rdy,
    output logic               o_pix_vld,
    output logic [DWD-1:0]     o_pix,
    input  logic               i_pix_rdy,
    output logic               o_busy,
    output logic [1:0]         o_state
);
    // Stream handshake: a sum transfers when i_sum_vld & o_sum_rdy at a rising
    // edge; a word transfers when o_pix_vld & i_pix_rdy, and o_pix/o_pix_vld
    // hold until that transfer.
    localparam int SW = $clog2(DWD);
    localparam int RW = ACCWD + 33;

    localparam logic [2:0] MODE_XNOR = 3'd0;
    localparam logic [2:0] MODE_M1   = 3'd1;
    localparam logic [2:0] MODE_M2   = 3'd2;
    localparam logic [2:0] MODE_M4   = 3'd3;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
    state_t state, state_nxt;

    logic [2:0]              mode_q;
    logic                    uns_q;
    logic [4:0]              shift_q;
    logic [7:0]              accnum_q;
    logic signed [ACCWD-1:0] acc;
    logic [7:0]              cnt;
    logic [SW-1:0]           slot;
    logic [DWD-1:0]          pack_q;

    logic                    accept, pix_done, word_done, uns_clip;
    logic signed [ACCWD-1:0] v;
    logic [8:0]              cnt_inc, acc_eff;
    logic [1:0]              lb;
    logic [7:0]              mask, pix_val;
    logic signed [RW-1:0]    rnd, r, hi, lo;
    logic [SW-1:0]           pos, slots_m1;
    logic [DWD-1:0]          word_nxt;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_cfg_vld) state_nxt = RUN;
            RUN:     if (accept && i_last) state_nxt = DRAIN;
            DRAIN:   if (o_pix_vld && i_pix_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_sum_rdy = (state == RUN) && (!o_pix_vld || i_pix_rdy);
        o_busy    = (state != IDLE);
        o_state   = state;
    end

    assign accept  = i_sum_vld && o_sum_rdy;
    assign v       = acc + ACCWD'($signed(i_sum));
    assign cnt_inc = {1'b0, cnt} + 9'd1;
    assign acc_eff = (accnum_q == 8'd0) ? 9'd1 : {1'b0, accnum_q};
    assign pix_done = accept && ((cnt_inc >= acc_eff) || i_last);

    // Requantization: log2 of the pixel width drives mask, clip range and slot layout.
    always_comb begin
        case (mode_q)
            MODE_XNOR, MODE_M1: lb = 2'd0;
            MODE_M2:            lb = 2'd1;
            MODE_M4:            lb = 2'd2;
            default:            lb = 2'd3;
        endcase
        case (lb)
            2'd0:    mask = 8'h01;
            2'd1:    mask = 8'h03;
            2'd2:    mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        uns_clip = uns_q || (mode_q == MODE_M1);
        hi  = uns_clip ? RW'(mask) : RW'(mask >> 1);
        lo  = uns_clip ? '0 : -RW'(mask >> 1) - RW'(1);
        rnd = (shift_q == 5'd0) ? '0 : (RW'(1) <<< (shift_q - 5'd1));
        r   = (RW'(v) + rnd) >>> shift_q;
        if (mode_q == MODE_XNOR)
            pix_val = {7'd0, ~v[ACCWD-1]};
        else
            pix_val = 8'((r > hi) ? hi : ((r < lo) ? lo : r)) & mask;
        pos       = slot << lb;
        slots_m1  = SW'((DWD >> lb) - 1);
        word_nxt  = pack_q | (DWD'(pix_val) << pos);
        word_done = pix_done && ((slot == slots_m1) || i_last);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            mode_q    <= '0;
            uns_q     <= 1'b0;
            shift_q   <= '0;
            accnum_q  <= '0;
            acc       <= '0;
            cnt       <= '0;
            slot      <= '0;
            pack_q    <= '0;
            o_pix     <= '0;
            o_pix_vld <= 1'b0;
        end else begin
            if (state == IDLE && i_cfg_vld) begin
                mode_q   <= i_mode;
                uns_q    <= i_oNumT;
                shift_q  <= i_shift;
                accnum_q <= i_accnum;
                acc      <= '0;
                cnt      <= '0;
                slot     <= '0;
                pack_q   <= '0;
            end
            if (accept) begin
                if (pix_done) begin
                    acc <= '0;
                    cnt <= '0;
                end else begin
                    acc <= v;
                    cnt <= cnt_inc[7:0];
                end
            end
            if (pix_done) begin
                if (word_done) begin
                    pack_q <= '0;
                    slot   <= '0;
                end else begin
                    pack_q <= word_nxt;
                    slot   <= slot + SW'(1);
                end
            end
            // A new word may load in the same cycle the previous one transfers.
            if (word_done) begin
                o_pix     <= word_nxt;
                o_pix_vld <= 1'b1;
            end else if (i_pix_rdy) begin
                o_pix_vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sum_requant_pack.sv
// Bench for sum_requant_pack: directed scenarios plus randomized runs, checked
// by a scoreboard fed from an integer-arithmetic reference model.
module tb_sum_requant_pack;
    localparam int XNOR = 0, M1 = 1, M2 = 2, M4 = 3, M8 = 4;
    localparam int SGN = 0, UNS = 1;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_cfg_vld = 1'b0;
    logic [2:0]  i_mode = '0;
    logic        i_oNumT = 1'b0;
    logic [4:0]  i_shift = '0;
    logic [7:0]  i_accnum = '0;
    logic        i_sum_vld = 1'b0;
    logic [17:0] i_sum = '0;
    logic        i_last = 1'b0;
    logic        o_sum_rdy;
    logic        o_pix_vld;
    logic [15:0] o_pix;
    logic        i_pix_rdy = 1'b1;
    logic        o_busy;
    logic [1:0]  o_state;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];
    bit rdy_rand = 1'b0;

    // reference model state
    int m_mode, m_shift, m_accnum, m_cnt, m_slot;
    bit m_uns;
    longint m_acc;
    logic [15:0] m_word;

    always #5 i_clk = ~i_clk;

    sum_requant_pack dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_cfg_vld(i_cfg_vld), .i_mode(i_mode),
        .i_oNumT(i_oNumT), .i_shift(i_shift), .i_accnum(i_accnum),
        .i_sum_vld(i_sum_vld), .i_sum(i_sum), .i_last(i_last),
        .o_sum_rdy(o_sum_rdy), .o_pix_vld(o_pix_vld), .o_pix(o_pix),
        .i_pix_rdy(i_pix_rdy), .o_busy(o_busy), .o_state(o_state)
    );

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int bits_of(input int mode);
        case (mode)
            M2:      return 2;
            M4:      return 4;
            M8:      return 8;
            default: return 1;
        endcase
    endfunction

    function automatic longint wrap24(input longint x);
        longint t;
        t = x & 64'hFFFFFF;
        if (t >= 64'sh800000) t = t - 64'sh1000000;
        return t;
    endfunction

    function automatic int quant(input longint v);
        int b;
        longint r, hi, lo;
        if (m_mode == XNOR) return (v >= 0) ? 1 : 0;
        b = bits_of(m_mode);
        r = v;
        if (m_shift > 0) r = r + (longint'(1) << (m_shift - 1));
        r = r >>> m_shift;
        if (m_uns || m_mode == M1) begin
            lo = 0;
            hi = (longint'(1) << b) - 1;
        end else begin
            hi = (longint'(1) << (b - 1)) - 1;
            lo = -(longint'(1) << (b - 1));
        end
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return int'(r) & ((1 << b) - 1);
    endfunction

    task automatic model_cfg(input int mode, input bit uns, input int shift, input int accnum);
        m_mode = mode; m_uns = uns; m_shift = shift; m_accnum = accnum;
        m_acc = 0; m_cnt = 0; m_slot = 0; m_word = '0;
    endtask

    task automatic model_sum(input int s, input bit last);
        longint v;
        int b, eff, p;
        b = bits_of(m_mode);
        eff = (m_accnum == 0) ? 1 : m_accnum;
        v = wrap24(m_acc + longint'(s));
        m_cnt++;
        if (m_cnt >= eff || last) begin
            p = quant(v);
            m_word = m_word | (16'(p) << (m_slot * b));
            m_slot++;
            m_acc = 0;
            m_cnt = 0;
            if (m_slot == 16 / b || last) begin
                exp_q.push_back(m_word);
                m_word = '0;
                m_slot = 0;
            end
        end else begin
            m_acc = v;
        end
    endtask

    // monitor: every transferred word is compared against the scoreboard head
    always @(negedge i_clk) begin
        if (i_rst && o_pix_vld && i_pix_rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word got=%0h expected=none at %0t", o_pix, $time);
            end else begin
                chk("word", longint'(o_pix), longint'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            if (rdy_rand) i_pix_rdy = 1'($urandom_range(0, 1));
        end
    end

    task automatic start_run(input int mode, input bit uns, input int shift, input int accnum);
        int n;
        n = 0;
        while (o_busy && n < 2000) begin
            @(posedge i_clk); #1;
            n++;
        end
        if (o_busy) chk("idle_timeout", 1, 0);
        i_cfg_vld = 1'b1;
        i_mode = 3'(mode); i_oNumT = uns; i_shift = 5'(shift); i_accnum = 8'(accnum);
        @(posedge i_clk); #1;
        i_cfg_vld = 1'b0;
        model_cfg(mode, uns, shift, accnum);
        chk("run_state", longint'(o_state), 1);
        chk("run_sum_rdy", longint'(o_sum_rdy), 1);
    endtask

    task automatic send_sum(input int s, input bit last);
        int n;
        bit ok;
        i_sum_vld = 1'b1;
        i_sum = 18'(s);
        i_last = last;
        n = 0;
        @(negedge i_clk);
        while (!o_sum_rdy && n < 300) begin
            n++;
            @(negedge i_clk);
        end
        ok = o_sum_rdy;
        if (!ok) chk("sum_accept_timeout", 0, 1);
        @(posedge i_clk); #1;
        i_sum_vld = 1'b0;
        i_last = 1'b0;
        if (ok) model_sum(s, last);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (o_busy && n < 2000) begin
            @(posedge i_clk); #1;
            n++;
        end
        chk("drain_to_idle", longint'(o_busy), 0);
    endtask

    initial begin
        int n_runs, n_sums, s;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_pix_vld", longint'(o_pix_vld), 0);
        chk("rst_pix", longint'(o_pix), 0);
        chk("rst_sum_rdy", longint'(o_sum_rdy), 0);
        chk("rst_busy", longint'(o_busy), 0);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        chk("idle_state", longint'(o_state), 0);

        // M8 unsigned: 5, 300 -> 0xFF05 one cycle after the second accept
        start_run(M8, UNS, 0, 1);
        send_sum(5, 0);
        send_sum(300, 0);
        chk("m8_vld", longint'(o_pix_vld), 1);
        chk("m8_word", longint'(o_pix), 16'hFF05);
        send_sum(17, 1);
        wait_idle();

        // M4 signed, accnum=2, shift=2 -> 0x87E3
        start_run(M4, SGN, 2, 2);
        send_sum(7, 0);    send_sum(6, 0);
        send_sum(-9, 0);   send_sum(-1, 0);
        send_sum(40, 0);   send_sum(0, 0);
        send_sum(-100, 0); send_sum(0, 1);
        chk("m4_word", longint'(o_pix), 16'h87E3);
        wait_idle();

        // XNOR: alternating -3, 4 -> 0xAAAA; i_last on the filling sum gives one word
        start_run(XNOR, SGN, 3, 1);
        for (int i = 0; i < 16; i++) send_sum((i % 2 == 0) ? -3 : 4, i == 15);
        chk("xnor_word", longint'(o_pix), 16'hAAAA);
        @(posedge i_clk); #1;
        chk("xnor_single_word", longint'(o_pix_vld), 0);
        wait_idle();

        // backpressure
        i_pix_rdy = 1'b0;
        start_run(M8, UNS, 0, 1);
        send_sum(10, 0);
        send_sum(20, 0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_sum_rdy", longint'(o_sum_rdy), 0);
            chk("bp_pix_vld", longint'(o_pix_vld), 1);
            chk("bp_pix_hold", longint'(o_pix), 16'h140A);
            @(posedge i_clk); #1;
        end
        i_pix_rdy = 1'b1;
        #1;
        chk("bp_release_rdy", longint'(o_sum_rdy), 1);
        send_sum(7, 1);
        wait_idle();

        // partial flush, M2 unsigned
        start_run(M2, UNS, 0, 1);
        send_sum(1, 0);
        send_sum(2, 0);
        send_sum(3, 1);
        chk("flush_word", longint'(o_pix), 16'h0039);
        @(posedge i_clk); #1;
        chk("flush_idle_state", longint'(o_state), 0);
        chk("flush_busy", longint'(o_busy), 0);

        // reset mid-run
        start_run(M8, UNS, 0, 1);
        send_sum(9, 0);
        i_rst = 1'b0;
        #1;
        chk("mid_rst_pix_vld", longint'(o_pix_vld), 0);
        chk("mid_rst_pix", longint'(o_pix), 0);
        chk("mid_rst_sum_rdy", longint'(o_sum_rdy), 0);
        chk("mid_rst_busy", longint'(o_busy), 0);
        model_cfg(M8, UNS, 0, 1);
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge i_clk);
            chk("post_rst_no_word", longint'(o_pix_vld), 0);
        end
        @(posedge i_clk); #1;
        start_run(M8, UNS, 0, 1);
        send_sum(1, 0);
        send_sum(2, 1);
        chk("post_rst_word", longint'(o_pix), 16'h0201);
        wait_idle();

        // randomized runs with random downstream readiness
        rdy_rand = 1'b1;
        n_runs = 10;
        for (int run = 0; run < n_runs; run++) begin
            start_run(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 6)), int'($urandom_range(0, 4)));
            n_sums = int'($urandom_range(1, 40));
            for (int k = 0; k < n_sums; k++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge i_clk); #1;
                end
                s = int'($urandom_range(0, 4000)) - 2000;
                send_sum(s, k == n_sums - 1);
            end
            wait_idle();
        end

        // accumulator wrap: 100 large sums per pixel exceed the 24-bit range
        start_run(M8, SGN, 16, 100);
        for (int k = 0; k < 200; k++) send_sum(131071 - int'($urandom_range(0, 7)), k == 199);
        wait_idle();

        rdy_rand = 1'b0;
        i_pix_rdy = 1'b1;
        repeat (5) @(posedge i_clk);
        #1;
        chk("scoreboard_empty", longint'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
